// File: rtl/priv_status_ctrl_pkg.sv
// Shared types, CSR addresses and mstatus layout for the privilege/trap-status unit.
package priv_pkg;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_mode_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEDELEG = 12'h302;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_SSTATUS = 12'h100;
    localparam logic [11:0] CSR_STVEC   = 12'h105;
    localparam logic [11:0] CSR_SEPC    = 12'h141;
    localparam logic [11:0] CSR_SCAUSE  = 12'h142;
    localparam logic [11:0] CSR_STVAL   = 12'h143;

    localparam int unsigned MS_SIE    = 1;
    localparam int unsigned MS_MIE    = 3;
    localparam int unsigned MS_SPIE   = 5;
    localparam int unsigned MS_MPIE   = 7;
    localparam int unsigned MS_SPP    = 8;
    localparam int unsigned MS_MPP_LO = 11;
    localparam int unsigned MS_MPP_HI = 12;
    localparam int unsigned MS_MPRV   = 17;
    localparam int unsigned MS_SUM    = 18;
    localparam int unsigned MS_MXR    = 19;
    localparam int unsigned MS_UXL_LO = 32;
    localparam int unsigned MS_UXL_HI = 33;

    function automatic logic [63:0] mstatus_wmask(input bit support_s);
        logic [63:0] m;
        m = '0;
        m[MS_MIE]    = 1'b1;
        m[MS_MPIE]   = 1'b1;
        m[MS_MPP_LO] = 1'b1;
        m[MS_MPP_HI] = 1'b1;
        m[MS_MPRV]   = 1'b1;
        m[MS_SUM]    = 1'b1;
        m[MS_MXR]    = 1'b1;
        if (support_s) begin
            m[MS_SIE]  = 1'b1;
            m[MS_SPIE] = 1'b1;
            m[MS_SPP]  = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [63:0] sstatus_wmask(input bit support_s);
        logic [63:0] m;
        m = '0;
        if (support_s) begin
            m[MS_SIE]  = 1'b1;
            m[MS_SPIE] = 1'b1;
            m[MS_SPP]  = 1'b1;
            m[MS_SUM]  = 1'b1;
            m[MS_MXR]  = 1'b1;
        end
        return m;
    endfunction

    // Read view adds UXL, which only exists in the 64-bit layout.
    function automatic logic [63:0] sstatus_rmask(input int unsigned n, input bit support_s);
        logic [63:0] m;
        m = sstatus_wmask(support_s);
        if (support_s && n == 64) begin
            m[MS_UXL_LO] = 1'b1;
            m[MS_UXL_HI] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [63:0] mstatus_reset(input int unsigned n);
        return (n == 64) ? 64'h0000_000A_0000_0000 : 64'h0;
    endfunction

endpackage

// File: rtl/priv_status_ctrl_trap_cause_arb.sv
// Lowest-index priority encoder over the trap request vector.
module trap_cause_arb #(
    parameter int unsigned NCAUSE = 16,
    parameter int unsigned CW     = $clog2(NCAUSE)
) (
    input  logic [NCAUSE-1:0] i_req,
    output logic              o_valid,
    output logic [CW-1:0]     o_cause
);

    always_comb begin
        o_valid = |i_req;
        o_cause = '0;
        for (int unsigned i = 0; i < NCAUSE; i++) begin
            if (i_req[NCAUSE-1-i]) begin
                o_cause = CW'(NCAUSE - 1 - i);
            end
        end
    end

endmodule

// File: rtl/priv_status_ctrl.sv
// Privilege mode, M/S trap CSRs, medeleg delegation and the RUN/FLUSH redirect handshake.
module priv_status_ctrl
    import priv_pkg::*;
#(
    parameter int unsigned N         = 64,
    parameter int unsigned NCAUSE    = 16,
    parameter bit          SUPPORT_S = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NCAUSE-1:0]         trapTrigger,
    input  logic [N-1:0]              trapPC,
    input  logic [N-1:0]              trapVal,
    input  logic                      mret,
    input  logic                      sret,
    input  logic                      csrWriteEnable,
    input  logic [11:0]               csrAddr,
    input  logic [N-1:0]              csrIn,
    input  logic                      flushAck,
    output logic [N-1:0]              csrOut,
    output logic [1:0]                currentMode,
    output logic [N-1:0]              mstatus,
    output logic                      trapTaken,
    output logic                      trapToS,
    output logic [$clog2(NCAUSE)-1:0] trapCause,
    output logic [N-1:0]              redirectPC
);

    localparam int unsigned CW = $clog2(NCAUSE);

    localparam logic [63:0]  MMASK64  = mstatus_wmask(SUPPORT_S);
    localparam logic [63:0]  SWMASK64 = sstatus_wmask(SUPPORT_S);
    localparam logic [63:0]  SRMASK64 = sstatus_rmask(N, SUPPORT_S);
    localparam logic [63:0]  MRST64   = mstatus_reset(N);
    localparam logic [N-1:0] MMASK    = MMASK64[N-1:0];
    localparam logic [N-1:0] SWMASK   = SWMASK64[N-1:0];
    localparam logic [N-1:0] SRMASK   = SRMASK64[N-1:0];
    localparam logic [N-1:0] MRST     = MRST64[N-1:0];

    state_e          r_state;
    priv_mode_e      r_mode;
    logic [N-1:0]    r_mstatus;
    logic [N-1:0]    r_medeleg;
    logic [N-1:0]    r_mtvec;
    logic [N-1:0]    r_mepc;
    logic [N-1:0]    r_mcause;
    logic [N-1:0]    r_mtval;
    logic [N-1:0]    r_stvec;
    logic [N-1:0]    r_sepc;
    logic [N-1:0]    r_scause;
    logic [N-1:0]    r_stval;
    logic            r_trap_taken;
    logic            r_trap_to_s;
    logic [CW-1:0]   r_trap_cause;

    logic            w_arb_valid;
    logic [CW-1:0]   w_arb_cause;
    logic [1:0]      w_mode_bits;
    logic [1:0]      w_mpp;
    logic            w_run;
    logic            w_trap;
    logic            w_to_s;
    logic            w_mret;
    logic            w_sret;
    logic            w_csr_we;
    logic [N-1:0]    w_epc;
    logic [N-1:0]    w_mstatus_wr;
    logic [N-1:0]    w_sstatus_wr;
    logic [N-1:0]    w_redirect;
    logic [N-1:0]    w_csr_rd;

    trap_cause_arb #(
        .NCAUSE (NCAUSE),
        .CW     (CW)
    ) u_arb (
        .i_req   (trapTrigger),
        .o_valid (w_arb_valid),
        .o_cause (w_arb_cause)
    );

    assign w_mode_bits = r_mode;
    assign w_mpp       = r_mstatus[MS_MPP_HI:MS_MPP_LO];
    assign w_run       = (r_state == ST_RUN);
    assign w_trap      = w_run && w_arb_valid;
    assign w_to_s      = SUPPORT_S && r_medeleg[w_arb_cause] && (r_mode != PRIV_M);
    assign w_mret      = w_run && !w_arb_valid && mret && (r_mode == PRIV_M);
    assign w_sret      = SUPPORT_S && w_run && !w_arb_valid && !w_mret && sret && (r_mode != PRIV_U);
    assign w_csr_we    = w_run && !w_arb_valid && !w_mret && !w_sret && csrWriteEnable;
    assign w_epc       = trapPC & ~N'(1);

    // MPP is WARL: an unsupported encoding leaves the previous value in place.
    always_comb begin
        w_mstatus_wr = (r_mstatus & ~MMASK) | (csrIn & MMASK);
        if (csrIn[MS_MPP_HI:MS_MPP_LO] == 2'b10 ||
            (csrIn[MS_MPP_HI:MS_MPP_LO] == 2'b01 && !SUPPORT_S)) begin
            w_mstatus_wr[MS_MPP_HI:MS_MPP_LO] = w_mpp;
        end
    end

    assign w_sstatus_wr = (r_mstatus & ~SWMASK) | (csrIn & SWMASK);

    always_comb begin
        w_redirect = '0;
        if (r_state == ST_FLUSH) begin
            w_redirect = r_trap_to_s ? r_stvec : r_mtvec;
        end else if (w_trap) begin
            w_redirect = w_to_s ? r_stvec : r_mtvec;
        end else if (w_mret) begin
            w_redirect = r_mepc;
        end else if (w_sret) begin
            w_redirect = r_sepc;
        end
    end

    always_comb begin
        w_csr_rd = '0;
        case (csrAddr)
            CSR_MSTATUS: w_csr_rd = r_mstatus;
            CSR_MEDELEG: w_csr_rd = r_medeleg;
            CSR_MTVEC:   w_csr_rd = r_mtvec;
            CSR_MEPC:    w_csr_rd = r_mepc;
            CSR_MCAUSE:  w_csr_rd = r_mcause;
            CSR_MTVAL:   w_csr_rd = r_mtval;
            CSR_SSTATUS: if (SUPPORT_S) w_csr_rd = r_mstatus & SRMASK;
            CSR_STVEC:   if (SUPPORT_S) w_csr_rd = r_stvec;
            CSR_SEPC:    if (SUPPORT_S) w_csr_rd = r_sepc;
            CSR_SCAUSE:  if (SUPPORT_S) w_csr_rd = r_scause;
            CSR_STVAL:   if (SUPPORT_S) w_csr_rd = r_stval;
            default:     w_csr_rd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_RUN;
            r_mode       <= PRIV_M;
            r_mstatus    <= MRST;
            r_medeleg    <= '0;
            r_mtvec      <= '0;
            r_mepc       <= '0;
            r_mcause     <= '0;
            r_mtval      <= '0;
            r_stvec      <= '0;
            r_sepc       <= '0;
            r_scause     <= '0;
            r_stval      <= '0;
            r_trap_taken <= 1'b0;
            r_trap_to_s  <= 1'b0;
            r_trap_cause <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_trap) begin
                        r_state      <= ST_FLUSH;
                        r_trap_taken <= 1'b1;
                        r_trap_to_s  <= w_to_s;
                        r_trap_cause <= w_arb_cause;
                        if (w_to_s) begin
                            r_mstatus[MS_SPP]  <= w_mode_bits[0];
                            r_mstatus[MS_SPIE] <= r_mstatus[MS_SIE];
                            r_mstatus[MS_SIE]  <= 1'b0;
                            r_mode             <= PRIV_S;
                            r_sepc             <= w_epc;
                            r_scause           <= N'(w_arb_cause);
                            r_stval            <= trapVal;
                        end else begin
                            r_mstatus[MS_MPP_HI:MS_MPP_LO] <= w_mode_bits;
                            r_mstatus[MS_MPIE]             <= r_mstatus[MS_MIE];
                            r_mstatus[MS_MIE]              <= 1'b0;
                            r_mode                         <= PRIV_M;
                            r_mepc                         <= w_epc;
                            r_mcause                       <= N'(w_arb_cause);
                            r_mtval                        <= trapVal;
                        end
                    end else if (w_mret) begin
                        r_mode                         <= priv_mode_e'(w_mpp);
                        r_mstatus[MS_MIE]              <= r_mstatus[MS_MPIE];
                        r_mstatus[MS_MPIE]             <= 1'b1;
                        r_mstatus[MS_MPP_HI:MS_MPP_LO] <= 2'b00;
                        if (w_mpp != 2'b11) begin
                            r_mstatus[MS_MPRV] <= 1'b0;
                        end
                    end else if (w_sret) begin
                        r_mode             <= priv_mode_e'({1'b0, r_mstatus[MS_SPP]});
                        r_mstatus[MS_SIE]  <= r_mstatus[MS_SPIE];
                        r_mstatus[MS_SPIE] <= 1'b1;
                        r_mstatus[MS_SPP]  <= 1'b0;
                    end else if (w_csr_we) begin
                        case (csrAddr)
                            CSR_MSTATUS: r_mstatus <= w_mstatus_wr;
                            CSR_MEDELEG: r_medeleg <= csrIn & ~(N'(1) << 11);
                            CSR_MTVEC:   r_mtvec   <= csrIn & ~N'(3);
                            CSR_MEPC:    r_mepc    <= csrIn & ~N'(1);
                            CSR_MCAUSE:  r_mcause  <= csrIn;
                            CSR_MTVAL:   r_mtval   <= csrIn;
                            CSR_SSTATUS: if (SUPPORT_S) r_mstatus <= w_sstatus_wr;
                            CSR_STVEC:   if (SUPPORT_S) r_stvec   <= csrIn & ~N'(3);
                            CSR_SEPC:    if (SUPPORT_S) r_sepc    <= csrIn & ~N'(1);
                            CSR_SCAUSE:  if (SUPPORT_S) r_scause  <= csrIn;
                            CSR_STVAL:   if (SUPPORT_S) r_stval   <= csrIn;
                            default: ;
                        endcase
                    end
                end
                ST_FLUSH: begin
                    if (flushAck) begin
                        r_state      <= ST_RUN;
                        r_trap_taken <= 1'b0;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign csrOut      = w_csr_rd;
    assign currentMode = r_mode;
    assign mstatus     = r_mstatus;
    assign trapTaken   = r_trap_taken;
    assign trapToS     = r_trap_to_s;
    assign trapCause   = r_trap_cause;
    assign redirectPC  = w_redirect;

endmodule

// File: tb/tb_priv_status_ctrl.sv
// Directed bench: CSR WARL vector table plus hand-written trap/xRET/reset sequences.
module tb_priv_status_ctrl;

    localparam int unsigned N      = 64;
    localparam int unsigned NCAUSE = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCAUSE-1:0] trapTrigger;
    logic [N-1:0]      trapPC;
    logic [N-1:0]      trapVal;
    logic              mret;
    logic              sret;
    logic              csrWriteEnable;
    logic [11:0]       csrAddr;
    logic [N-1:0]      csrIn;
    logic              flushAck;
    logic [N-1:0]      csrOut;
    logic [1:0]        currentMode;
    logic [N-1:0]      mstatus;
    logic              trapTaken;
    logic              trapToS;
    logic [3:0]        trapCause;
    logic [N-1:0]      redirectPC;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    priv_status_ctrl #(
        .N         (N),
        .NCAUSE    (NCAUSE),
        .SUPPORT_S (1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .trapTrigger    (trapTrigger),
        .trapPC         (trapPC),
        .trapVal        (trapVal),
        .mret           (mret),
        .sret           (sret),
        .csrWriteEnable (csrWriteEnable),
        .csrAddr        (csrAddr),
        .csrIn          (csrIn),
        .flushAck       (flushAck),
        .csrOut         (csrOut),
        .currentMode    (currentMode),
        .mstatus        (mstatus),
        .trapTaken      (trapTaken),
        .trapToS        (trapToS),
        .trapCause      (trapCause),
        .redirectPC     (redirectPC)
    );

    typedef struct {
        logic        we;
        logic [11:0] waddr;
        logic [63:0] wdata;
        logic [11:0] raddr;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%h required=0x%h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [63:0] d);
        csrWriteEnable = 1'b1;
        csrAddr        = a;
        csrIn          = d;
        step();
        csrWriteEnable = 1'b0;
    endtask

    task automatic csr_chk(input string name, input logic [11:0] a, input logic [63:0] exp);
        csrAddr = a;
        #1;
        chk(name, csrOut, exp);
    endtask

    task automatic ack();
        flushAck = 1'b1;
        step();
        flushAck = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; trapTrigger = '0; trapPC = '0; trapVal = '0;
        mret = 1'b0; sret = 1'b0; csrWriteEnable = 1'b0; csrAddr = '0;
        csrIn = '0; flushAck = 1'b0;

        vecs[0]  = '{1'b1, 12'h300, 64'h1800,               12'h300, 64'h0000_000A_0000_1800};
        vecs[1]  = '{1'b1, 12'h300, 64'h1000,               12'h300, 64'h0000_000A_0000_1800};
        vecs[2]  = '{1'b1, 12'h300, 64'h0800,               12'h300, 64'h0000_000A_0000_0800};
        vecs[3]  = '{1'b1, 12'h300, 64'h0,                  12'h300, 64'h0000_000A_0000_0000};
        vecs[4]  = '{1'b1, 12'h100, 64'hFFFF_FFFF_FFFF_FFFF, 12'h300, 64'h0000_000A_000C_0122};
        vecs[5]  = '{1'b0, 12'h000, 64'h0,                  12'h100, 64'h0000_0002_000C_0122};
        vecs[6]  = '{1'b1, 12'h300, 64'h0,                  12'h300, 64'h0000_000A_0000_0000};
        vecs[7]  = '{1'b1, 12'h302, 64'hFFFF_FFFF_FFFF_FFFF, 12'h302, 64'hFFFF_FFFF_FFFF_F7FF};
        vecs[8]  = '{1'b1, 12'h305, 64'h8000_0103,          12'h305, 64'h8000_0100};
        vecs[9]  = '{1'b1, 12'h341, 64'h8000_0103,          12'h341, 64'h8000_0102};
        vecs[10] = '{1'b1, 12'h105, 64'h4000_0207,          12'h105, 64'h4000_0204};
        vecs[11] = '{1'b1, 12'h141, 64'h4000_0201,          12'h141, 64'h4000_0200};
        vecs[12] = '{1'b1, 12'h342, 64'h5,                  12'h342, 64'h5};
        vecs[13] = '{1'b1, 12'h343, 64'hDEAD,               12'h343, 64'hDEAD};
        vecs[14] = '{1'b0, 12'h000, 64'h0,                  12'h7C0, 64'h0};
        vecs[15] = '{1'b1, 12'h302, 64'h0,                  12'h302, 64'h0};

        // Reset values
        #2 reset = 1'b0;
        step();
        chk("rst_mode",    64'(currentMode), 64'h3);
        chk("rst_mstatus", mstatus,          64'h0000_000A_0000_0000);
        chk("rst_taken",   64'(trapTaken),   64'h0);
        chk("rst_tos",     64'(trapToS),     64'h0);
        chk("rst_cause",   64'(trapCause),   64'h0);
        csr_chk("rst_mtvec", 12'h305, 64'h0);
        reset = 1'b1;
        step();

        // CSR write/read WARL table
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].we) csr_wr(vecs[i].waddr, vecs[i].wdata);
            else step();
            csr_chk($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
        end

        // M trap, cause 2, MIE=1
        csr_wr(12'h300, 64'h8);
        trapTrigger = 16'h0004; trapPC = 64'h8000_0102; trapVal = 64'h1234;
        step();
        trapTrigger = '0;
        chk("mtrap_taken", 64'(trapTaken), 64'h1);
        chk("mtrap_cause", 64'(trapCause), 64'h2);
        chk("mtrap_tos",   64'(trapToS),   64'h0);
        chk("mtrap_redir", redirectPC,     64'h8000_0100);
        chk("mtrap_mstat", mstatus,        64'h0000_000A_0000_1880);
        chk("mtrap_mode",  64'(currentMode), 64'h3);
        csr_chk("mtrap_mepc",   12'h341, 64'h8000_0102);
        csr_chk("mtrap_mcause", 12'h342, 64'h2);
        csr_wr(12'h343, 64'h999);
        csr_chk("flush_ignore_wr", 12'h343, 64'h1234);
        chk("flush_hold", 64'(trapTaken), 64'h1);
        ack();
        chk("flush_done", 64'(trapTaken), 64'h0);

        // Drop to U via mret, then delegated S trap cause 8
        csr_wr(12'h302, 64'h100);
        csr_wr(12'h300, 64'h0);
        mret = 1'b1;
        #1;
        chk("mret_u_redir", redirectPC, 64'h8000_0102);
        step();
        mret = 1'b0;
        chk("mret_u_mode",  64'(currentMode), 64'h0);
        chk("mret_u_mstat", mstatus, 64'h0000_000A_0000_0080);
        trapTrigger = 16'h0100; trapPC = 64'h1001; trapVal = 64'h77;
        step();
        trapTrigger = '0;
        chk("strap_tos",   64'(trapToS),     64'h1);
        chk("strap_cause", 64'(trapCause),   64'h8);
        chk("strap_mode",  64'(currentMode), 64'h1);
        chk("strap_redir", redirectPC,       64'h4000_0204);
        chk("strap_mstat", mstatus,          64'h0000_000A_0000_0080);
        csr_chk("strap_scause", 12'h142, 64'h8);
        csr_chk("strap_sepc",   12'h141, 64'h1000);
        csr_chk("strap_stval",  12'h143, 64'h77);
        csr_chk("strap_mepc",   12'h341, 64'h8000_0102);
        ack();

        // Undelegated cause from S goes to M, then cause 8 in M stays in M
        trapTrigger = 16'h0004; trapPC = 64'h1500;
        step();
        trapTrigger = '0;
        chk("s2m_mode",  64'(currentMode), 64'h3);
        chk("s2m_mstat", mstatus,          64'h0000_000A_0000_0800);
        ack();
        trapTrigger = 16'h0100; trapPC = 64'h2000;
        step();
        trapTrigger = '0;
        chk("m8_tos",   64'(trapToS),   64'h0);
        chk("m8_cause", 64'(trapCause), 64'h8);
        chk("m8_redir", redirectPC,     64'h8000_0100);
        chk("m8_mstat", mstatus,        64'h0000_000A_0000_1800);
        csr_chk("m8_mcause", 12'h342, 64'h8);
        csr_chk("m8_mepc",   12'h341, 64'h2000);
        ack();

        // Arbitration and a cause held across flushAck
        trapTrigger = 16'h0024;
        step();
        chk("arb_lowest", 64'(trapCause), 64'h2);
        trapTrigger = 16'h0020;
        step();
        chk("arb_flush_ignore", 64'(trapCause), 64'h2);
        ack();
        chk("held_run", 64'(trapTaken), 64'h0);
        step();
        trapTrigger = '0;
        chk("held_taken", 64'(trapTaken), 64'h1);
        chk("held_cause", 64'(trapCause), 64'h5);
        ack();

        // mret with MPP=01, MPRV=1
        csr_wr(12'h300, 64'h2_0800);
        csr_wr(12'h341, 64'h3004);
        mret = 1'b1;
        #1;
        chk("mret_s_redir", redirectPC, 64'h3004);
        step();
        mret = 1'b0;
        chk("mret_s_mode",  64'(currentMode), 64'h1);
        chk("mret_s_mstat", mstatus,          64'h0000_000A_0000_0080);

        // Back to M, then trap and mret in the same cycle
        trapTrigger = 16'h0004; trapPC = 64'h4000;
        step();
        trapTrigger = '0;
        ack();
        chk("pre_race_mstat", mstatus, 64'h0000_000A_0000_0800);
        trapTrigger = 16'h0004; trapPC = 64'h5000; mret = 1'b1;
        step();
        trapTrigger = '0; mret = 1'b0;
        chk("race_taken", 64'(trapTaken),   64'h1);
        chk("race_mode",  64'(currentMode), 64'h3);
        chk("race_mstat", mstatus,          64'h0000_000A_0000_1800);
        csr_chk("race_mepc", 12'h341, 64'h5000);

        // Asynchronous reset while in FLUSH
        #2 reset = 1'b0;
        #1;
        chk("areset_taken", 64'(trapTaken),   64'h0);
        chk("areset_mode",  64'(currentMode), 64'h3);
        chk("areset_mstat", mstatus,          64'h0000_000A_0000_0000);
        csr_chk("areset_mepc", 12'h341, 64'h0);
        step();
        reset = 1'b1;
        step();
        chk("areset_run", 64'(trapTaken), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
